// File: rtl/latch_driver_if.sv
// Command handshake plus latch drive pins for latch_driver.
// master issues commands and watches the pins; slave is the sequencer itself.
interface latch_driver_if #(
   parameter int LAT_Width = 1
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [LAT_Width-1:0] cmd_data;
   logic [LAT_Width-1:0] d;
   logic                 gate;
   logic                 aset;
   logic                 aclr;
   logic                 busy;
   logic                 done;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, d, gate, aset, aclr, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, d, gate, aset, aclr, busy, done
   );
endinterface

// File: rtl/latch_driver.sv
// Sequences WRITE/SET/CLEAR commands into glitch-free d/gate/aset/aclr drive; WRITE takes SETUP+GATE+HOLD cycles, SET/CLEAR take CTRL.
// Only one command is in flight: cmd_ready is high only in IDLE, and a command may be accepted in the done cycle.
module latch_driver #(
   parameter int LAT_Width = 1,
   parameter int SETUP_CYC = 1,
   parameter int GATE_CYC  = 2,
   parameter int HOLD_CYC  = 1,
   parameter int CTRL_CYC  = 2
) (
   input  logic           clk,
   input  logic           rst,
   latch_driver_if.slave  bus
);

   localparam int MAX_SG  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
   localparam int MAX_HC  = (HOLD_CYC > CTRL_CYC) ? HOLD_CYC : CTRL_CYC;
   localparam int MAX_CYC = (MAX_SG > MAX_HC) ? MAX_SG : MAX_HC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      GATE  = 3'd2,
      HOLD  = 3'd3,
      CTRL  = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [LAT_Width-1:0] d_q, d_nxt;
   logic                 gate_q, gate_nxt;
   logic                 aset_q, aset_nxt;
   logic                 aclr_q, aclr_nxt;
   logic                 done_q, done_nxt;
   logic                 accept;
   logic                 cnt_zero;

   assign bus.cmd_ready = (state == IDLE) && !rst;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign cnt_zero      = (cnt == '0);

   // The counter holds "cycles remaining minus one" for the current phase.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      d_nxt     = d_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (bus.cmd_op)
                  OP_WR: begin
                     state_nxt = SETUP;
                     cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                     d_nxt     = bus.cmd_data;
                  end
                  OP_SET, OP_CLR: begin
                     state_nxt = CTRL;
                     cnt_nxt   = CNT_W'(CTRL_CYC - 1);
                  end
                  default: done_nxt = 1'b1;
               endcase
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               state_nxt = GATE;
               cnt_nxt   = CNT_W'(GATE_CYC - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         GATE: begin
            if (cnt_zero) begin
               state_nxt = HOLD;
               cnt_nxt   = CNT_W'(HOLD_CYC - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         HOLD, CTRL: begin
            if (cnt_zero) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Pins are registered from the next state so they never glitch.
      gate_nxt = (state_nxt == GATE);
      aset_nxt = (state_nxt == CTRL) && (accept ? (bus.cmd_op == OP_SET) : aset_q);
      aclr_nxt = (state_nxt == CTRL) && (accept ? (bus.cmd_op == OP_CLR) : aclr_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         d_q    <= '0;
         gate_q <= 1'b0;
         aset_q <= 1'b0;
         aclr_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         d_q    <= d_nxt;
         gate_q <= gate_nxt;
         aset_q <= aset_nxt;
         aclr_q <= aclr_nxt;
         done_q <= done_nxt;
      end
   end

   assign bus.d    = d_q;
   assign bus.gate = gate_q;
   assign bus.aset = aset_q;
   assign bus.aclr = aclr_q;
   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;

   a_set_clr_excl: assert property (@(posedge clk) !(aset_q && aclr_q));
   a_gate_ctrl_excl: assert property (@(posedge clk) !(gate_q && (aset_q || aclr_q)));
   a_d_stable: assert property (@(posedge clk) disable iff (rst)
      (d_q != $past(d_q)) |-> ($past(rst) || ($past(accept) && !$past(gate_q))));

endmodule

// File: tb/tb_latch_driver.sv
// Drives a default-width and an 8-bit latch_driver in lockstep and checks every pin against a cycle-count model.
module tb_latch_driver;

   localparam int S = 1;
   localparam int G = 2;
   localparam int H = 1;
   localparam int C = 2;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] model_d = 8'h00;

   always #5 clk = ~clk;

   latch_driver_if #(.LAT_Width(1)) ifa ();
   latch_driver_if #(.LAT_Width(8)) ifb ();

   latch_driver dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   latch_driver #(.LAT_Width(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk8(tag, {7'b0, obs}, {7'b0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] dat);
      ifa.cmd_valid = v;
      ifa.cmd_op    = op;
      ifa.cmd_data  = dat[0];
      ifb.cmd_valid = v;
      ifb.cmd_op    = op;
      ifb.cmd_data  = dat;
   endtask

   task automatic expect_all(input string tag, input logic g, input logic as, input logic ac,
                             input logic b, input logic dn, input logic rd);
      chk1($sformatf("%s gate_a", tag), ifa.gate, g);
      chk1($sformatf("%s gate_b", tag), ifb.gate, g);
      chk1($sformatf("%s aset_a", tag), ifa.aset, as);
      chk1($sformatf("%s aset_b", tag), ifb.aset, as);
      chk1($sformatf("%s aclr_a", tag), ifa.aclr, ac);
      chk1($sformatf("%s aclr_b", tag), ifb.aclr, ac);
      chk1($sformatf("%s busy_a", tag), ifa.busy, b);
      chk1($sformatf("%s busy_b", tag), ifb.busy, b);
      chk1($sformatf("%s done_a", tag), ifa.done, dn);
      chk1($sformatf("%s done_b", tag), ifb.done, dn);
      chk1($sformatf("%s ready_a", tag), ifa.cmd_ready, rd);
      chk1($sformatf("%s ready_b", tag), ifb.cmd_ready, rd);
      chk1($sformatf("%s d_a", tag), ifa.d, model_d[0]);
      chk8($sformatf("%s d_b", tag), ifb.d, model_d);
   endtask

   // Presents a command in the current cycle (cycle 0), then walks it cycle by
   // cycle to its done cycle, leaving nv/nop/ndat on the bus meanwhile.
   // abort_at > 0 pulses rst during that cycle and checks the discard.
   task automatic issue(input logic [1:0] op, input logic [7:0] dat, input logic nv,
                        input logic [1:0] nop, input logic [7:0] ndat, input int abort_at);
      int t;
      drive(1'b1, op, dat);
      #1;
      chk1("accept ready_a", ifa.cmd_ready, 1'b1);
      chk1("accept ready_b", ifb.cmd_ready, 1'b1);
      t = (op == OP_WR) ? (S + G + H) : (op == OP_NOP) ? 0 : C;
      step();
      drive(nv, nop, ndat);
      if (op == OP_WR) model_d = dat;
      for (int c = 1; c <= t + 1; c++) begin
         expect_all($sformatf("op%0d c%0d", op, c),
                    (op == OP_WR) && (c >= S + 1) && (c <= S + G),
                    (op == OP_SET) && (c <= t),
                    (op == OP_CLR) && (c <= t),
                    c <= t, c == t + 1, c == t + 1);
         if (c == abort_at) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            #1;
            model_d = 8'h00;
            expect_all("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            return;
         end
         if (c <= t) step();
      end
   endtask

   initial begin
      logic [7:0] rdat;

      // Reset with a WRITE presented: nothing may be accepted.
      rst = 1'b1;
      drive(1'b1, OP_WR, 8'h01);
      repeat (3) begin
         step();
         expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0;
      drive(1'b0, OP_NOP, 8'h00);
      #1;
      expect_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      issue(OP_WR, 8'h01, 1'b0, OP_NOP, 8'h00, 0);

      // CLEAR then SET back-to-back; d must keep its written value.
      issue(OP_CLR, 8'h00, 1'b1, OP_SET, 8'h00, 0);
      issue(OP_SET, 8'h00, 1'b0, OP_NOP, 8'h00, 0);

      // cmd_valid held high across two WRITEs.
      issue(OP_WR, 8'h00, 1'b1, OP_WR, 8'h01, 0);
      issue(OP_WR, 8'h01, 1'b0, OP_NOP, 8'h00, 0);

      // Reset while gate is high, then one more WRITE runs normally.
      issue(OP_WR, 8'h01, 1'b0, OP_NOP, 8'h00, 2);
      step();
      expect_all("post_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_WR, 8'h01, 1'b0, OP_NOP, 8'h00, 0);

      issue(OP_NOP, 8'hA5, 1'b0, OP_NOP, 8'h00, 0);

      for (int i = 0; i < 50; i++) begin
         rdat = 8'($urandom_range(0, 255));
         issue(OP_WR, rdat, 1'b0, OP_NOP, 8'h00, 0);
         if ($urandom_range(0, 1) == 1) begin
            step();
            expect_all("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
